// File: rtl/regfile_wb_controller_if.sv
// Purpose: writeback request/grant bundle between the ALU/MEM requesters and
//          the register-file write sequencer, plus the registered write port.
// Signals: AluValid/AluRd/AluData/AluReady  - ALU writeback handshake
//          MemValid/MemRd/MemData/MemReady  - MEM (load) writeback handshake
//          RegWr/RW/BusW                    - register file write port
//          InitDone                         - register clear sequence complete
// Modports: master = requesters/observer side, slave = the controller.
interface regfile_wb_controller_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              AluValid;
  logic [ADDR_W-1:0] AluRd;
  logic [DATA_W-1:0] AluData;
  logic              AluReady;
  logic              MemValid;
  logic [ADDR_W-1:0] MemRd;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic              RegWr;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;
  logic              InitDone;

  modport master (
    output AluValid, AluRd, AluData, MemValid, MemRd, MemData,
    input  AluReady, MemReady, RegWr, RW, BusW, InitDone
  );

  modport slave (
    input  AluValid, AluRd, AluData, MemValid, MemRd, MemData,
    output AluReady, MemReady, RegWr, RW, BusW, InitDone
  );
endinterface

// File: rtl/regfile_wb_controller.sv
// Purpose: sequences the single write port of a 32 x 64-bit register file.
//          After reset it clears X0..X30 one per cycle, then arbitrates the
//          port between MEM (priority) and ALU writebacks, with an anti-
//          starvation counter that forces an ALU grant after MAX_WAIT losses.
// Ports:   Clk    - clock, all state changes on the rising edge
//          Rst_n  - asynchronous active-low reset
//          bus    - slave side of regfile_wb_controller_if (handshakes in,
//                   combinational Ready out, registered write port out)
module regfile_wb_controller #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  regfile_wb_controller_if.slave   bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ZERO_REG - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_busw;
  logic              r_init_done;

  logic w_force_alu;
  logic w_alu_gnt;
  logic w_mem_gnt;

  // Grant logic: MEM wins by default; ALU wins alone or once it has lost
  // MAX_WAIT times in a row. Gated by InitDone so the transition edge into
  // RUN cannot also carry a write.
  always_comb begin
    w_force_alu = 1'b0;
    w_alu_gnt   = 1'b0;
    w_mem_gnt   = 1'b0;
    if (r_init_done) begin
      w_force_alu = bus.AluValid && bus.MemValid && (r_wait == WAIT_MAX);
      w_alu_gnt   = bus.AluValid && (!bus.MemValid || w_force_alu);
      w_mem_gnt   = bus.MemValid && !w_alu_gnt;
    end
  end

  assign bus.AluReady = w_alu_gnt;
  assign bus.MemReady = w_mem_gnt;
  assign bus.RegWr    = r_reg_wr;
  assign bus.RW       = r_rw;
  assign bus.BusW     = r_busw;
  assign bus.InitDone = r_init_done;

  // State machine with registered write-port outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_wait      <= '0;
      r_reg_wr    <= 1'b0;
      r_rw        <= '0;
      r_busw      <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_reg_wr <= 1'b1;
          r_rw     <= r_idx;
          r_busw   <= '0;
          r_idx    <= r_idx + ADDR_W'(1);
          if (r_idx == LAST_IDX) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
          r_reg_wr    <= 1'b0;
          if (w_alu_gnt) begin
            // A grant to the zero register is consumed without writing.
            if (bus.AluRd != ZERO_IDX) begin
              r_reg_wr <= 1'b1;
              r_rw     <= bus.AluRd;
              r_busw   <= bus.AluData;
            end
            r_wait <= '0;
          end else if (w_mem_gnt) begin
            if (bus.MemRd != ZERO_IDX) begin
              r_reg_wr <= 1'b1;
              r_rw     <= bus.MemRd;
              r_busw   <= bus.MemData;
            end
            if (bus.AluValid && (r_wait != WAIT_MAX)) r_wait <= r_wait + WAIT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_wb_controller.md
Name: regfile_wb_controller

Overview:
- Sequences the single write port of the 32 x 64-bit register file, whose writes are latched on the falling edge of Clk.
- After reset it clears X0..X30 to zero, one register per cycle.
- It then arbitrates the write port between two writeback requesters: MEM (load data) and ALU (execute results).
- All write-port outputs are registered on the rising edge of Clk, so they are stable at the register file's falling-edge write.

Parameters:
- DATA_W, 64, width of write data.
- ADDR_W, 5, width of register index.
- ZERO_REG, 31, index of the hardwired zero register (XZR); writes to it are never issued.
- MAX_WAIT, 3, number of consecutive cycles ALU may lose to MEM before ALU is forced to win.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- AluValid  in  1  ALU has a writeback pending.
- AluRd  in  ADDR_W  ALU destination register.
- AluData  in  DATA_W  ALU result.
- AluReady  out  1  ALU request accepted this cycle (combinational).
- MemValid  in  1  MEM has a writeback pending.
- MemRd  in  ADDR_W  MEM destination register.
- MemData  in  DATA_W  load data.
- MemReady  out  1  MEM request accepted this cycle (combinational).
- RegWr  out  1  register file write enable (registered).
- RW  out  ADDR_W  register file write index (registered).
- BusW  out  DATA_W  register file write data (registered).
- InitDone  out  1  clear sequence complete (registered).

Behaviour:
- Reset (Rst_n=0, asynchronous): RegWr=0, RW=0, BusW=0, InitDone=0, state=INIT, clear index=0, wait counter=0.
- FSM has two states, INIT and RUN.
- INIT:
  - Each rising edge loads RegWr=1, RW=index, BusW=0, then increments the index.
  - Edge k after reset release (k=1..31) presents RW=k-1.
  - When RW=30 is loaded, next state is RUN.
  - AluReady=MemReady=0 throughout INIT; requests are held, not dropped.
- Transition: at the first edge in RUN, RegWr=0 and InitDone=1. InitDone stays 1 until reset.
- RUN arbitration (combinational):
  - Default priority is MEM over ALU.
  - If AluValid and MemValid are both set and the wait counter equals MAX_WAIT, ALU is granted.
  - Only the granted requester sees Ready=1; Ready never asserts without its Valid.
- Accept means Valid&&Ready at a rising edge.
  - Latency is 1: at that edge RegWr=1, RW=Rd, BusW=Data.
  - If nothing is accepted, RegWr=0 and RW/BusW hold their previous values.
- Zero-register drop:
  - A request whose Rd==ZERO_REG still takes the grant and is accepted, but loads RegWr=0.
  - Dropping takes one grant slot; a simultaneous request from the other side waits as normal.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each edge where AluValid=1 and MEM is accepted.
  - Clears on ALU accept.
  - Holds otherwise, including when AluValid drops.
  - Width is clog2(MAX_WAIT+1).
- One write per cycle; no data merging, buffering or reordering. Requesters hold Valid/Rd/Data stable until accepted.
- Reset mid-operation (INIT or RUN) aborts immediately and restarts the full clear sequence. Any in-flight write is lost.

Test Plan:
- Release reset, no requests:
  - RW steps 0..30 with RegWr=1 and BusW=0 on edges 1..31.
  - Edge 32 gives RegWr=0 and InitDone=1.
  - No Ready asserts before InitDone.
- After init, AluValid with AluRd=5, AluData=64'hDEAD_BEEF:
  - AluReady=1.
  - Next edge gives RegWr=1, RW=5, BusW=64'hDEAD_BEEF.
  - The following edge gives RegWr=0.
- MemValid and AluValid held continuously (MEM Rd=2, ALU Rd=7), MAX_WAIT=3:
  - Grants are MEM, MEM, MEM, ALU, then MEM resumes.
  - RW sequence is 2,2,2,7,2.
- AluValid with AluRd=31 alone:
  - AluReady=1, then RegWr=0 on the next edge.
  - Wait counter clears.
- Assert Rst_n=0 for 1 cycle while RW=12 in INIT:
  - RegWr=0 and InitDone=0 immediately, without waiting for a clock edge.
  - After release, RW restarts at 0.
- Assert Rst_n=0 in RUN during a MEM accept:
  - Outputs clear asynchronously.
  - The held MemValid is not granted until the new InitDone=1.
